// File: rtl/led_pkg.sv
// Shared definitions for the LED pulse driver: state encoding, ICEstick timing
// defaults and the timer sizing rule.
package led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2
    } led_state_e;

    // 100 ms at the 12 MHz ICEstick clock
    localparam int DEF_ON_CYCLES  = 1200000;
    localparam int DEF_OFF_CYCLES = 1200000;
    localparam int DEF_PEND_MAX   = 7;

    function automatic int timer_width(input int on_c, input int off_c);
        int m;
        m = (on_c > off_c) ? on_c : off_c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/led_pulse_driver_cycle_timer.sv
// Loadable down-counter that parks at zero; the zero flag tells the FSM a phase
// has run its full length.
module cycle_timer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    always_comb begin
        if (load) begin
            count_d = load_val;
        end else if (count_q != {WIDTH{1'b0}}) begin
            count_d = count_q - WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == {WIDTH{1'b0}});

endmodule

// File: rtl/led_pulse_driver.sv
// Stretches single-cycle events into fixed-length LED blinks separated by a
// minimum dark gap, queueing events that arrive mid-blink in a saturating counter.
module led_pulse_driver
    import led_pkg::*;
#(
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int PEND_MAX   = DEF_PEND_MAX,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            event_in,
    output logic                            led_out,
    output logic                            busy,
    output logic [$clog2(PEND_MAX+1)-1:0]   pend_count,
    output logic                            overflow
);

    localparam int TW = timer_width(ON_CYCLES, OFF_CYCLES);
    localparam int PW = $clog2(PEND_MAX + 1);

    led_state_e    state_d, state_q;
    logic [PW-1:0] pend_d, pend_q;
    logic          overflow_d, overflow_q;
    logic          led_d, led_q;
    logic          busy_d, busy_q;
    logic          timer_load;
    logic [TW-1:0] timer_load_val;
    logic          timer_zero;
    logic          dec;
    logic          pend_nz;

    cycle_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    assign pend_nz = (pend_q != {PW{1'b0}});

    always_comb begin
        state_d        = state_q;
        timer_load     = 1'b0;
        timer_load_val = {TW{1'b0}};
        dec            = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_nz) begin
                    state_d        = ST_ON;
                    timer_load     = 1'b1;
                    timer_load_val = TW'(ON_CYCLES - 1);
                    dec            = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ON: begin
                if (timer_zero) begin
                    state_d        = ST_GAP;
                    timer_load     = 1'b1;
                    timer_load_val = TW'(OFF_CYCLES - 1);
                end else begin
                    state_d = ST_ON;
                end
            end
            ST_GAP: begin
                // A queued event skips IDLE so back-to-back blinks keep the minimum gap only
                if (timer_zero && pend_nz) begin
                    state_d        = ST_ON;
                    timer_load     = 1'b1;
                    timer_load_val = TW'(ON_CYCLES - 1);
                    dec            = 1'b1;
                end else if (timer_zero) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        pend_d     = pend_q;
        overflow_d = overflow_q;
        if (event_in && !dec) begin
            if (pend_q == PW'(PEND_MAX)) begin
                overflow_d = 1'b1;
            end else begin
                pend_d = pend_q + PW'(1);
            end
        end else if (dec && !event_in) begin
            pend_d = pend_q - PW'(1);
        end else begin
            pend_d = pend_q;
        end
        led_d  = (state_d == ST_ON) ^ ACTIVE_LOW;
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_q     <= {PW{1'b0}};
            overflow_q <= 1'b0;
            led_q      <= ACTIVE_LOW;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
        end
    end

    assign led_out    = led_q;
    assign busy       = busy_q;
    assign pend_count = pend_q;
    assign overflow   = overflow_q;

endmodule
